// File: rtl/alu_instr_encoder.sv
// ALU request to R-format instruction encoder with an output FIFO and issued/illegal counters.
// Optional macro ENC_NOR_EN: makes ALUOp 4'b1100 legal, encoding func 6'b100111 (nor).
module alu_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_aluop,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             err_illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  // Returns {legal, func}; unsupported codes return all zeros.
  function automatic logic [6:0] func_lookup(input logic [3:0] aluop);
    logic [6:0] res;
    case (aluop)
      4'b0010: res = {1'b1, 6'b100000};
      4'b0110: res = {1'b1, 6'b100010};
      4'b0000: res = {1'b1, 6'b100100};
      4'b0001: res = {1'b1, 6'b100101};
      4'b0111: res = {1'b1, 6'b101010};
`ifdef ENC_NOR_EN
      4'b1100: res = {1'b1, 6'b100111};
`endif
      default: res = 7'b0000000;
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [DEPTH];
  logic              err_q, err_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  illegal_q, illegal_d;

  logic [6:0]        lookup_s;
  logic              accept_s, push_s, pop_s;
  logic [31:0]       word_s;

  // Handshake decode, occupancy, pointer, counter and state next-values
  always_comb begin
    lookup_s  = func_lookup(req_aluop);
    word_s    = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, lookup_s[5:0]};
    accept_s  = req_valid && req_ready;
    push_s    = accept_s && lookup_s[6];
    pop_s     = instr_valid && instr_ready;

    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    issued_d  = issued_q;
    illegal_d = illegal_q;
    err_d     = accept_s && !lookup_s[6];

    if (push_s && !pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end

    if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else        wr_ptr_d = wr_ptr_q;

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      issued_d = issued_q + CNT_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
      issued_d = issued_q;
    end

    if (err_d) illegal_d = illegal_q + CNT_W'(1);
    else       illegal_d = illegal_q;

    // State mirrors the next occupancy so it stays in lockstep with count_q.
    if (count_d == (AW+1)'(0))  state_d = ST_EMPTY;
    else if (count_d == FULL_CNT) state_d = ST_FULL;
    else                        state_d = ST_PARTIAL;
  end

  // Control state, pointers and counters with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
      issued_q  <= '0;
      illegal_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
      issued_q  <= issued_d;
      illegal_q <= illegal_d;
    end
  end

  // FIFO storage; contents are don't-care until covered by the occupancy count
  always_ff @(posedge clock) begin
    if (push_s && !reset) mem_q[wr_ptr_q] <= word_s;
  end

  always_comb begin
    req_ready   = (state_q != ST_FULL);
    instr_valid = (state_q != ST_EMPTY);
    instr       = instr_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;
    err_illegal = err_q;
    issued_cnt  = issued_q;
    illegal_cnt = illegal_q;
  end

endmodule

// File: doc/alu_instr_encoder.md
Name: alu_instr_encoder

Overview:
- Encoder counterpart to the control decoder: turns ALU operation requests (ALUOp code plus register fields) into 32-bit R-format instruction words.
- Fed by the test sequencer over a valid/ready interface.
- Buffers encoded words in a small FIFO and presents them to the instruction-memory loader / datapath instruction input over a second valid/ready interface.
- Rejects ALUOp codes that have no R-format encoding and counts them.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, 8, width of issued and illegal counters

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  encoder can accept a request this cycle
req_aluop  input  4  ALU operation code
req_rs  input  5  source register 1
req_rt  input  5  source register 2
req_rd  input  5  destination register
instr_valid  output  1  instr holds a valid encoded word
instr_ready  input  1  consumer takes the word this cycle
instr  output  32  encoded instruction word
err_illegal  output  1  one-cycle pulse: an accepted request had an unsupported ALUOp
issued_cnt  output  CNT_W  words popped by the consumer
illegal_cnt  output  CNT_W  rejected requests

Behaviour:
- Single clock domain `clock`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - FIFO empty; read/write pointers 0.
  - instr_valid=0, instr=32'h0.
  - err_illegal=0, issued_cnt=0, illegal_cnt=0.
  - req_ready=1 in the cycle after reset deasserts.
- Reset mid-operation: all buffered words are discarded; no partial output survives.
- Accept rule: request accepted when req_valid && req_ready.
  - req_ready = !full; combinational from FIFO occupancy only, not from req_valid.
- Encoding, R-format fields:
  - [31:26] opcode = 6'b000000
  - [25:21] rs, [20:16] rt, [15:11] rd
  - [10:6] shamt = 5'b0
  - [5:0] func
- ALUOp -> func:
  - 0010 -> 100000 (add)
  - 0110 -> 100010 (sub)
  - 0000 -> 100100 (and)
  - 0001 -> 100101 (or)
  - 0111 -> 101010 (slt)
- Any other ALUOp is illegal:
  - The request is still accepted (handshake completes) but nothing is written to the FIFO.
  - err_illegal=1 in the following cycle only.
  - illegal_cnt increments.
- Legal accepted request: encoded word written to the FIFO tail at the clock edge.
- Output side:
  - instr_valid = !empty; instr = FIFO head, taken from registered storage.
  - Latency: a request accepted at edge N is visible on instr after edge N (earliest cycle N+1). Zero-cycle fall-through is not allowed.
  - Pop when instr_valid && instr_ready; issued_cnt increments.
  - instr and instr_valid hold stable while instr_valid && !instr_ready.
- Occupancy and boundaries:
  - Occupancy tracked with an explicit count (0..DEPTH); pointers wrap modulo DEPTH.
  - Simultaneous push and pop, not full: both happen and count is unchanged. If the FIFO is empty, the pushed word appears the next cycle.
  - Full: req_ready=0 even if a pop occurs the same cycle. No push-through when full.
  - Empty: instr_valid=0; instr_ready is ignored; no counter change.
  - Illegal request while full cannot occur, since req_ready=0.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation or flag.
- Control FSM: EMPTY, PARTIAL, FULL, derived from count and updated registered.
  - EMPTY -> PARTIAL on a legal push without pop.
  - PARTIAL -> FULL when count reaches DEPTH.
  - PARTIAL -> EMPTY when count reaches 0.
  - FULL -> PARTIAL on a pop.
  - Outputs req_ready and instr_valid are decoded from the state.

Optional Feature:
- Macro ENC_NOR_EN.
- Defined: ALUOp 1100 is legal and encodes func 100111 (nor).
- Undefined: 1100 is illegal (err_illegal pulse, illegal_cnt++, no FIFO write).

Test Plan:
- Reset, then one request aluop=0010 rs=1 rt=2 rd=3 with instr_ready=1 -> next cycle instr=32'h00221820, instr_valid=1 for one cycle, issued_cnt=1.
- instr_ready=0; push 4 legal requests (sub, and, or, slt; rs=4 rt=5 rd=6) -> req_ready=0 after the 4th. A 5th req_valid is held off. Release instr_ready -> words pop in order with func 22, 24, 25, 2A; req_ready returns after the first pop.
- Request aluop=1111 -> accepted, err_illegal pulses exactly one cycle, illegal_cnt=1, instr_valid stays 0.
- FIFO holding 2 words, simultaneous push and pop -> count stays 2, order preserved, issued_cnt+1.
- Reset asserted with 3 words buffered -> next cycle instr_valid=0, counters 0, req_ready=1.
- aluop=1100 rs=7 rt=8 rd=9 -> with ENC_NOR_EN: instr=32'h00E84827. Without it: err_illegal pulse, no word.
